// File: rtl/l2_mem_ctrl.sv
// Front-end controller for the 64-bit L2 SRAM wrapper: zero-fills memory after reset,
// then serves req/gnt accesses with in-order responses through a small skid FIFO.
module l2_mem_ctrl #(
  parameter int MEM_ADDR_WIDTH = 13,
  parameter int RESP_DEPTH     = 2,
  parameter int INIT_ON_RESET  = 1
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               add_i,
  input  logic                      we_i,
  input  logic [7:0]                be_i,
  input  logic [63:0]               wdata_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [63:0]               r_rdata_o,
  output logic                      r_we_o,
  output logic                      mem_cen_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a_o,
  output logic [63:0]               mem_d_o,
  output logic [7:0]                mem_be_o,
  input  logic [63:0]               mem_q_i,
  output logic                      init_done_o
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1) + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] init_cnt_reg;
  logic                      init_done_reg;
  logic                      inflight_reg, inflight_we_reg;
  logic [CNT_W-1:0]          count_reg;
  logic [PTR_W-1:0]          rd_ptr_reg, wr_ptr_reg;
  logic [64:0]               fifo_mem [RESP_DEPTH];

  logic                      fifo_empty, fifo_push, fifo_pop, pop;
  logic [63:0]               inflight_data;
  logic [64:0]               head;
  logic [CNT_W-1:0]          occ_after_pop;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{add_i[31:MEM_ADDR_WIDTH+3], add_i[2:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // State register and fill counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_done_reg <= (state_next == ST_RUN);
      if (state_reg == ST_INIT) init_cnt_reg <= init_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && init_cnt_reg == '1) state_next = ST_RUN;
  end

  assign init_done_o = init_done_reg;

  // Response selection: FIFO head when non-empty, otherwise bypass from the in-flight stage.
  assign fifo_empty    = (count_reg == '0);
  assign inflight_data = inflight_we_reg ? 64'h0 : mem_q_i;
  assign head          = fifo_mem[rd_ptr_reg];
  assign r_valid_o     = ~fifo_empty | inflight_reg;
  assign r_rdata_o     = fifo_empty ? (inflight_reg ? inflight_data : 64'h0) : head[63:0];
  assign r_we_o        = fifo_empty ? (inflight_reg & inflight_we_reg) : head[64];

  assign pop       = r_valid_o & r_ready_i;
  assign fifo_pop  = ~fifo_empty & r_ready_i;
  assign fifo_push = inflight_reg & ~(fifo_empty & r_ready_i);

  // occ never exceeds RESP_DEPTH, and pop implies occ >= 1, so this cannot underflow.
  assign occ_after_pop = count_reg + CNT_W'(inflight_reg) - CNT_W'(pop);
  assign gnt_o = RSTN & (state_reg == ST_RUN) & req_i & (occ_after_pop < CNT_W'(RESP_DEPTH));

  // Memory drive; gated by RSTN so reset forces the idle pattern immediately.
  always_comb begin
    mem_cen_o = 1'b1;
    mem_wen_o = 1'b1;
    mem_a_o   = '0;
    mem_d_o   = '0;
    mem_be_o  = '0;
    if (RSTN && state_reg == ST_INIT) begin
      mem_cen_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_a_o   = init_cnt_reg;
      mem_be_o  = 8'hFF;
    end else if (gnt_o) begin
      mem_cen_o = 1'b0;
      mem_wen_o = ~we_i;
      mem_a_o   = add_i[MEM_ADDR_WIDTH+2:3];
      mem_d_o   = wdata_i;
      mem_be_o  = be_i;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight_reg    <= 1'b0;
      inflight_we_reg <= 1'b0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      inflight_reg    <= gnt_o;
      inflight_we_reg <= gnt_o & we_i;
      if (fifo_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (fifo_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  // The read data is captured here because the memory output is only valid for one cycle.
  always_ff @(posedge CLK) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= {inflight_we_reg, inflight_data};
  end

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Randomized scoreboard bench for l2_mem_ctrl with a behavioural SRAM and reference memory.
module tb_l2_mem_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int WORDS = 1 << AW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          req_i = 1'b0, gnt_o;
  logic [31:0]   add_i = '0;
  logic          we_i = 1'b0;
  logic [7:0]    be_i = '0;
  logic [63:0]   wdata_i = '0;
  logic          r_valid_o, r_ready_i = 1'b1, r_we_o;
  logic [63:0]   r_rdata_o;
  logic          mem_cen_o, mem_wen_o;
  logic [AW-1:0] mem_a_o;
  logic [63:0]   mem_d_o, mem_q_i;
  logic [7:0]    mem_be_o;
  logic          init_done_o;

  always #5 CLK = ~CLK;

  l2_mem_ctrl #(.MEM_ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH), .INIT_ON_RESET(1)) dut (
    .CLK(CLK), .RSTN(RSTN), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .r_rdata_o(r_rdata_o), .r_we_o(r_we_o), .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o),
    .mem_a_o(mem_a_o), .mem_d_o(mem_d_o), .mem_be_o(mem_be_o), .mem_q_i(mem_q_i),
    .init_done_o(init_done_o)
  );

  // SRAM wrapper: Q is valid only in the cycle after a read, garbage otherwise.
  logic [63:0] sram [WORDS];
  always @(posedge CLK) begin
    if (!mem_cen_o && !mem_wen_o)
      for (int b = 0; b < 8; b++)
        if (mem_be_o[b]) sram[mem_a_o][8*b +: 8] <= mem_d_o[8*b +: 8];
    if (!mem_cen_o && mem_wen_o) mem_q_i <= sram[mem_a_o];
    else                         mem_q_i <= {$urandom, $urandom};
  end

  logic [63:0] ref_mem [WORDS];
  logic [64:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every accepted response, plus hold-while-stalled check.
  logic        prev_hold = 1'b0;
  logic [64:0] prev_resp = '0;
  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {64'h0, r_valid_o}, 65'h1);
        chk("hold_data", {r_we_o, r_rdata_o}, prev_resp);
      end
      if (r_valid_o && r_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_resp: got we=%0d data=%h expected no response", r_we_o, r_rdata_o);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          $display("resp we=%0d data=%h", r_we_o, r_rdata_o);
          chk("resp", {r_we_o, r_rdata_o}, e);
        end
      end
      prev_hold = r_valid_o && !r_ready_i;
      prev_resp = {r_we_o, r_rdata_o};
    end
  end

  // Called at the negedge of a granted cycle: checks the memory drive and updates the model.
  task automatic on_grant();
    int idx;
    idx = int'(add_i[AW+2:3]);
    $display("grant we=%0d add=%h be=%h wdata=%h", we_i, add_i, be_i, wdata_i);
    chk("mem_cen", {64'h0, mem_cen_o}, 65'h0);
    chk("mem_wen", {64'h0, mem_wen_o}, {64'h0, ~we_i});
    chk("mem_a", {61'h0, mem_a_o}, {61'h0, add_i[AW+2:3]});
    if (we_i) begin
      chk("mem_be", {57'h0, mem_be_o}, {57'h0, be_i});
      chk("mem_d", {1'b0, mem_d_o}, {1'b0, wdata_i});
      for (int b = 0; b < 8; b++)
        if (be_i[b]) ref_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
      exp_q.push_back({1'b1, 64'h0});
    end else begin
      exp_q.push_back({1'b0, ref_mem[idx]});
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] be,
                       input logic [63:0] data, output bit granted);
    req_i = 1'b1; we_i = we; add_i = addr; be_i = be; wdata_i = data;
    @(negedge CLK);
    granted = gnt_o;
    if (granted) on_grant();
    @(posedge CLK); #1;
    req_i = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [7:0] be,
                        input logic [63:0] data);
    bit g;
    g = 1'b0;
    for (int i = 0; i < 50 && !g; i++) issue(we, addr, be, data, g);
    if (!g) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected grant within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(posedge CLK); #1;
    end
    chk("drain_left", 65'(exp_q.size()), 65'h0);
  endtask

  // Fill check: requests are held high to show that INIT never grants.
  task automatic init_phase();
    req_i = 1'b1; we_i = 1'b0; add_i = 32'h38;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge CLK);
      chk("init_cen", {64'h0, mem_cen_o}, 65'h0);
      chk("init_wen", {64'h0, mem_wen_o}, 65'h0);
      chk("init_a", {61'h0, mem_a_o}, 65'(i));
      chk("init_d", {1'b0, mem_d_o}, 65'h0);
      chk("init_be", {57'h0, mem_be_o}, 65'hFF);
      chk("init_gnt", {64'h0, gnt_o}, 65'h0);
      chk("init_done_low", {64'h0, init_done_o}, 65'h0);
      @(posedge CLK); #1;
    end
    req_i = 1'b0;
    @(negedge CLK);
    chk("init_done_high", {64'h0, init_done_o}, 65'h1);
    chk("run_idle_cen", {64'h0, mem_cen_o}, 65'h1);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'h0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int grants;
    for (int i = 0; i < WORDS; i++) sram[i] = {$urandom, $urandom};
    req_i = 1'b1;
    #2;
    chk("rst_gnt", {64'h0, gnt_o}, 65'h0);
    chk("rst_rvalid", {64'h0, r_valid_o}, 65'h0);
    chk("rst_rdata", {r_we_o, r_rdata_o}, 65'h0);
    chk("rst_cen", {64'h0, mem_cen_o}, 65'h1);
    chk("rst_wen", {64'h0, mem_wen_o}, 65'h1);
    chk("rst_a", {61'h0, mem_a_o}, 65'h0);
    chk("rst_d", {1'b0, mem_d_o}, 65'h0);
    chk("rst_be", {57'h0, mem_be_o}, 65'h0);
    chk("rst_init_done", {64'h0, init_done_o}, 65'h0);
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    init_phase();

    // Fill result, full write, then partial write over it
    do_txn(1'b0, 32'h38, 8'h00, 64'h0);
    do_txn(1'b1, 32'h40, 8'hFF, 64'h1122334455667788);
    do_txn(1'b0, 32'h40, 8'h00, 64'h0);
    @(negedge CLK);
    chk("read_latency", {64'h0, r_valid_o}, 65'h1);
    @(posedge CLK); #1;
    do_txn(1'b1, 32'h40, 8'h0F, 64'hAAAAAAAABBBBBBBB);
    do_txn(1'b0, 32'hFFFF_FF40, 8'h00, 64'h0);
    do_txn(1'b1, 32'h48, 8'h00, 64'hDEAD);
    do_txn(1'b0, 32'h48, 8'h00, 64'h0);

    for (int k = 0; k < 4; k++) do_txn(1'b1, 32'(k * 8), 8'hFF, {$urandom, $urandom});
    drain();

    // Backpressure: only DEPTH reads can be outstanding
    r_ready_i = 1'b0;
    grants = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 32'(k * 8), 8'h00, 64'h0, g);
      if (g) grants++;
    end
    chk("bp_grants", 65'(grants), 65'(DEPTH));
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    chk("bp_valid", {64'h0, r_valid_o}, 65'h1);
    @(posedge CLK); #1;
    r_ready_i = 1'b1;
    for (int k = 2; k < 4; k++) do_txn(1'b0, 32'(k * 8), 8'h00, 64'h0);
    drain();

    // Streaming: one transaction per cycle
    for (int k = 0; k < 9; k++) begin
      req_i = (k < 8); we_i = 1'b0; add_i = 32'(k * 8);
      @(negedge CLK);
      if (k < 8) begin
        chk("stream_gnt", {64'h0, gnt_o}, 65'h1);
        if (gnt_o) on_grant();
      end
      if (k >= 1) chk("stream_valid", {64'h0, r_valid_o}, 65'h1);
      @(posedge CLK); #1;
    end
    req_i = 1'b0;
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      req_i = $urandom_range(0, 1);
      we_i = $urandom_range(0, 1);
      add_i = $urandom;
      be_i = 8'($urandom);
      wdata_i = {$urandom, $urandom};
      r_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      if (req_i && gnt_o) on_grant();
      @(posedge CLK); #1;
    end
    req_i = 1'b0;
    r_ready_i = 1'b1;
    drain();

    // Reset with two responses pending
    r_ready_i = 1'b0;
    do_txn(1'b0, 32'h08, 8'h00, 64'h0);
    do_txn(1'b0, 32'h10, 8'h00, 64'h0);
    req_i = 1'b1;
    #2 RSTN = 1'b0;
    #1;
    chk("midrst_rvalid", {64'h0, r_valid_o}, 65'h0);
    chk("midrst_cen", {64'h0, mem_cen_o}, 65'h1);
    chk("midrst_gnt", {64'h0, gnt_o}, 65'h0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    r_ready_i = 1'b1;
    init_phase();
    do_txn(1'b0, 32'h40, 8'h00, 64'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
